multi_alarm_clock: RTL and testbench
====================================

Name: multi_alarm_clock

Overview:
Parametrised successor to the single-alarm timekeeper. It combines a 24-hour time-of-day counter with an internal prescaler, manual time set, and NUM_ALARMS independently programmable alarm slots. The alarm controller supports ring timeout, snooze and dismiss, and the block provides an hourly chime. It sits between the board button/switch conditioning and the display mux, and replaces the separate clock, alarm and hour-remind blocks.

Parameters:
CLK_FREQ, 1000, clk cycles per second (>=2)
NUM_ALARMS, 4, number of alarm slots (1..16); IDW = max(1, clog2(NUM_ALARMS))
RING_SEC, 60, seconds an alarm rings before auto-dismiss (>=1)
SNOOZE_MIN, 5, snooze length in minutes (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
set_mode  in  1  1 = time frozen for manual setting
inc_hour  in  1  level; each rising edge increments hour while set_mode=1
inc_min  in  1  level; each rising edge increments minute while set_mode=1
alm_wr  in  1  one-cycle write strobe for an alarm slot
alm_sel  in  IDW  slot index for the write
alm_wr_hour  in  5  alarm hour, 0..23
alm_wr_min  in  6  alarm minute, 0..59
alm_wr_en  in  1  slot enable bit to write
snooze  in  1  level; acted on at its rising edge
dismiss  in  1  level; acted on at its rising edge
hour  out  5  current hour, binary 0..23
min  out  6  current minute, binary 0..59
sec  out  6  current second, binary 0..59
sec_pulse  out  1  one-cycle strobe when the time advances
hour_chime  out  1  high for the whole of second hh:00:00
ringing  out  1  alarm is ringing
snoozed  out  1  alarm is in snooze
ring_id  out  IDW  slot that triggered the current ring/snooze
alm_en  out  NUM_ALARMS  per-slot enable readback

Behaviour:
- Reset (rst=0, async): time 00:00:00, prescaler 0, all slots hour=0/min=0/en=0, FSM IDLE, all outputs 0, edge-detect history registers 0.
- Prescaler: counts 0..CLK_FREQ-1.
  - At the terminal count it wraps and asserts sec_pulse in the same cycle; sec/min/hour update on that edge.
  - Carry chain: sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0.
- set_mode=1:
  - Prescaler and sec are held at 0; sec_pulse=0; the ring/snooze timers freeze.
  - Rising edge of inc_hour gives hour+1 mod 24. Rising edge of inc_min gives min+1 mod 60, with no carry into hour.
  - Edges are detected against a registered copy of the input; the value updates on the clk edge at which input=1 and history=0.
  - Edges while set_mode=0 are ignored.
- Leaving set_mode: the prescaler restarts from 0, so the first sec_pulse comes CLK_FREQ cycles later.
- Alarm write: on an alm_wr cycle the selected slot loads hour, min and en; it is visible next cycle. A write does not affect an ongoing ring or snooze. Out-of-range hour/min values are stored but can never match.
- Match: on a sec_pulse cycle where the new time is hh:mm:00, set_mode=0, and slot k is enabled with equal hour/min, slot k matches.
- FSM: IDLE, RING, SNOOZE.
  - IDLE: any match moves to RING on the same edge. ring_id = lowest matching index. Ring counter = 0.
  - RING: each sec_pulse increments the ring counter.
    - Counter reaching RING_SEC moves to IDLE (auto-dismiss).
    - dismiss edge moves to IDLE.
    - snooze edge moves to SNOOZE, with the snooze counter loaded to SNOOZE_MIN*60.
  - SNOOZE: each sec_pulse decrements the snooze counter. Reaching 0 moves to RING with the same ring_id and the ring counter cleared. dismiss edge moves to IDLE.
  - Matches arriving while not in IDLE are dropped.
  - dismiss and snooze edges in the same cycle: dismiss wins.
  - snooze edge in IDLE is ignored.
- ringing = (state==RING); snoozed = (state==SNOOZE). ring_id holds its last value in IDLE.
- hour_chime = (set_mode==0 && min==0 && sec==0), taken from the registered time. It is low after reset at 00:00:00 until the first rollover into an hour.

Test Plan:
Common parameters for all scenarios: CLK_FREQ=4, NUM_ALARMS=4, RING_SEC=3, SNOOZE_MIN=1.

- Set 23:59 via set_mode with 23 inc_hour pulses and 59 inc_min pulses, then release. After 60 s the time reads 00:00:00 with sec_pulse, and hour_chime is high for exactly 4 cycles.
- set_mode at min=59, one inc_min pulse -> min=0 and hour unchanged. Holding inc_min high for 10 cycles gives exactly one increment.
- Slots 1 and 2 both programmed to 00:01 en=1, time 00:00:59 -> on the sec_pulse to 00:01:00, ringing=1 next cycle with ring_id=1. After 3 more sec_pulses ringing=0 and state is IDLE.
- While ringing, a snooze edge -> ringing=0, snoozed=1. 60 sec_pulses later ringing=1 with ring_id unchanged. A dismiss edge then gives ringing=0 and snoozed=0.
- snooze and dismiss rising in the same cycle during RING -> IDLE, snoozed stays 0. A slot write to ring_id's slot during RING leaves ringing=1.
- Assert rst low asynchronously mid-RING (between clk edges) -> outputs go 0 immediately. After release, time reads 00:00:00 and alm_en=0000.

Source files
------------

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour time-of-day counter with internal prescaler,
// manual time set, NUM_ALARMS programmable alarm slots, a ring/snooze/dismiss
// controller and an hourly chime.
module multi_alarm_clock #(
  parameter int CLK_FREQ   = 1000,
  parameter int NUM_ALARMS = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int IDW       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_mode,
  input  logic                  inc_hour,
  input  logic                  inc_min,
  input  logic                  alm_wr,
  input  logic [IDW-1:0]        alm_sel,
  input  logic [4:0]            alm_wr_hour,
  input  logic [5:0]            alm_wr_min,
  input  logic                  alm_wr_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [4:0]            hour,
  output logic [5:0]            min,
  output logic [5:0]            sec,
  output logic                  sec_pulse,
  output logic                  hour_chime,
  output logic                  ringing,
  output logic                  snoozed,
  output logic [IDW-1:0]        ring_id,
  output logic [NUM_ALARMS-1:0] alm_en
);

  localparam int PW        = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int RW        = $clog2(RING_SEC + 1);
  localparam int SW        = $clog2(SNZ_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_FREQ - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  // Timekeeping state
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          sec_pulse_q;
  logic          hour_chime_q;
  logic          tick_s;

  // Input edge-detect history
  logic inc_hour_q, inc_min_q, snooze_q, dismiss_q;
  logic inc_hour_rise_s, inc_min_rise_s, snooze_rise_s, dismiss_rise_s;

  // Alarm slots
  logic [4:0]            slot_hour_q [NUM_ALARMS];
  logic [5:0]            slot_min_q  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_en_q;
  logic [NUM_ALARMS-1:0] hit_s;
  logic                  match_any_s;
  logic [IDW-1:0]        match_id_s;

  // Alarm controller
  state_e         state_q;
  logic           ringing_q, snoozed_q;
  logic [IDW-1:0] ring_id_q;
  logic [RW-1:0]  ring_cnt_q;
  logic [SW-1:0]  snz_cnt_q;

  assign inc_hour_rise_s = inc_hour & ~inc_hour_q;
  assign inc_min_rise_s  = inc_min  & ~inc_min_q;
  assign snooze_rise_s   = snooze   & ~snooze_q;
  assign dismiss_rise_s  = dismiss  & ~dismiss_q;

  // Next time value: manual set, prescaler wrap with sec/min/hour carry, or count
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    tick_s  = 1'b0;
    if (set_mode) begin
      presc_d = '0;
      sec_d   = 6'd0;
      if (inc_hour_rise_s) begin
        hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
      end else begin
        hour_d = hour_q;
      end
      if (inc_min_rise_s) begin
        min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
      end else begin
        min_d = min_q;
      end
    end else if (presc_q == PRE_LAST) begin
      tick_s  = 1'b1;
      presc_d = '0;
      if (sec_q >= 6'd59) begin
        sec_d = 6'd0;
        if (min_q >= 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Per-slot match against the time being entered; the lowest index wins
  always_comb begin
    match_any_s = 1'b0;
    match_id_s  = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      hit_s[k] = tick_s && (sec_d == 6'd0) && slot_en_q[k] &&
                 (slot_hour_q[k] == hour_d) && (slot_min_q[k] == min_d);
    end
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (hit_s[k]) begin
        match_any_s = 1'b1;
        match_id_s  = IDW'(k);
      end else begin
        match_id_s  = match_id_s;
      end
    end
  end

  // Time registers, second strobe and hourly chime (chime aligned with hh:00:00)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= '0;
      sec_q        <= 6'd0;
      min_q        <= 6'd0;
      hour_q       <= 5'd0;
      sec_pulse_q  <= 1'b0;
      hour_chime_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sec_pulse_q <= tick_s;
      if (set_mode) begin
        hour_chime_q <= 1'b0;
      end else if (tick_s) begin
        hour_chime_q <= (min_d == 6'd0) && (sec_d == 6'd0);
      end else begin
        hour_chime_q <= hour_chime_q;
      end
    end
  end

  // Registered copies of the level inputs for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      snooze_q   <= 1'b0;
      dismiss_q  <= 1'b0;
    end else begin
      inc_hour_q <= inc_hour;
      inc_min_q  <= inc_min;
      snooze_q   <= snooze;
      dismiss_q  <= dismiss;
    end
  end

  // Alarm slot storage; out-of-range values are kept as written and never match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        slot_hour_q[k] <= 5'd0;
        slot_min_q[k]  <= 6'd0;
      end
      slot_en_q <= '0;
    end else begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (alm_wr && (alm_sel == IDW'(k))) begin
          slot_hour_q[k] <= alm_wr_hour;
          slot_min_q[k]  <= alm_wr_min;
          slot_en_q[k]   <= alm_wr_en;
        end else begin
          slot_hour_q[k] <= slot_hour_q[k];
          slot_min_q[k]  <= slot_min_q[k];
          slot_en_q[k]   <= slot_en_q[k];
        end
      end
    end
  end

  // Ring/snooze controller with registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ringing_q  <= 1'b0;
      snoozed_q  <= 1'b0;
      ring_id_q  <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match_any_s) begin
            state_q    <= ST_RING;
            ringing_q  <= 1'b1;
            snoozed_q  <= 1'b0;
            ring_id_q  <= match_id_s;
            ring_cnt_q <= '0;
          end else begin
            ringing_q <= 1'b0;
            snoozed_q <= 1'b0;
          end
        end
        ST_RING: begin
          if (dismiss_rise_s) begin
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
            snoozed_q <= 1'b0;
          end else if (snooze_rise_s) begin
            state_q   <= ST_SNOOZE;
            ringing_q <= 1'b0;
            snoozed_q <= 1'b1;
            snz_cnt_q <= SNZ_LOAD;
          end else if (tick_s) begin
            if (ring_cnt_q == RING_LAST) begin
              state_q   <= ST_IDLE;
              ringing_q <= 1'b0;
              snoozed_q <= 1'b0;
            end else begin
              ring_cnt_q <= ring_cnt_q + RW'(1);
            end
          end else begin
            ring_cnt_q <= ring_cnt_q;
          end
        end
        ST_SNOOZE: begin
          if (dismiss_rise_s) begin
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
            snoozed_q <= 1'b0;
          end else if (tick_s) begin
            if (snz_cnt_q <= SW'(1)) begin
              state_q    <= ST_RING;
              ringing_q  <= 1'b1;
              snoozed_q  <= 1'b0;
              ring_cnt_q <= '0;
              snz_cnt_q  <= '0;
            end else begin
              snz_cnt_q <= snz_cnt_q - SW'(1);
            end
          end else begin
            snz_cnt_q <= snz_cnt_q;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          ringing_q <= 1'b0;
          snoozed_q <= 1'b0;
        end
      endcase
    end
  end

  assign hour       = hour_q;
  assign min        = min_q;
  assign sec        = sec_q;
  assign sec_pulse  = sec_pulse_q;
  assign hour_chime = hour_chime_q;
  assign ringing    = ringing_q;
  assign snoozed    = snoozed_q;
  assign ring_id    = ring_id_q;
  assign alm_en     = slot_en_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed self-checking bench for multi_alarm_clock with
// CLK_FREQ=4, NUM_ALARMS=4, RING_SEC=3, SNOOZE_MIN=1.
module tb_multi_alarm_clock;

  logic       clk;
  logic       rst;
  logic       set_mode, inc_hour, inc_min;
  logic       alm_wr;
  logic [1:0] alm_sel;
  logic [4:0] alm_wr_hour;
  logic [5:0] alm_wr_min;
  logic       alm_wr_en;
  logic       snooze, dismiss;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       sec_pulse, hour_chime, ringing, snoozed;
  logic [1:0] ring_id;
  logic [3:0] alm_en;

  int n_checks = 0;
  int n_pass   = 0;

  multi_alarm_clock #(
    .CLK_FREQ(4), .NUM_ALARMS(4), .RING_SEC(3), .SNOOZE_MIN(1)
  ) dut (
    .clk(clk), .rst(rst), .set_mode(set_mode), .inc_hour(inc_hour),
    .inc_min(inc_min), .alm_wr(alm_wr), .alm_sel(alm_sel),
    .alm_wr_hour(alm_wr_hour), .alm_wr_min(alm_wr_min), .alm_wr_en(alm_wr_en),
    .snooze(snooze), .dismiss(dismiss), .hour(hour), .min(min), .sec(sec),
    .sec_pulse(sec_pulse), .hour_chime(hour_chime), .ringing(ringing),
    .snoozed(snoozed), .ring_id(ring_id), .alm_en(alm_en)
  );

  // 10-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 unit after the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_hour();
    inc_hour = 1'b1; step(1);
    inc_hour = 1'b0; step(1);
  endtask

  task automatic pulse_min();
    inc_min = 1'b1; step(1);
    inc_min = 1'b0; step(1);
  endtask

  task automatic write_slot(input int s, input int h, input int m, input bit en);
    alm_sel     = 2'(s);
    alm_wr_hour = 5'(h);
    alm_wr_min  = 6'(m);
    alm_wr_en   = en;
    alm_wr      = 1'b1;
    step(1);
    alm_wr      = 1'b0;
  endtask

  initial begin
    int chime_cycles;
    rst = 1'b0; set_mode = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;
    alm_wr = 1'b0; alm_sel = 2'd0; alm_wr_hour = 5'd0; alm_wr_min = 6'd0;
    alm_wr_en = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    step(3);

    // Reset state
    check_val("rst_hour", hour, 0);
    check_val("rst_min", min, 0);
    check_val("rst_sec", sec, 0);
    check_val("rst_sec_pulse", sec_pulse, 0);
    check_val("rst_chime", hour_chime, 0);
    check_val("rst_ringing", ringing, 0);
    check_val("rst_alm_en", alm_en, 0);

    // Set 23:59 manually, then let it roll over midnight
    rst = 1'b1; set_mode = 1'b1;
    step(1);
    for (int i = 0; i < 23; i++) pulse_hour();
    for (int i = 0; i < 59; i++) pulse_min();
    check_val("set_hour", hour, 23);
    check_val("set_min", min, 59);
    check_val("set_sec", sec, 0);
    set_mode = 1'b0;
    step(3);
    check_val("first_sec_not_early", sec, 0);
    step(1);
    check_val("first_sec_pulse", sec_pulse, 1);
    check_val("first_sec", sec, 1);
    step(232);
    check_val("pre_mid_sec", sec, 59);
    check_val("pre_mid_chime", hour_chime, 0);
    step(4);
    check_val("mid_hour", hour, 0);
    check_val("mid_min", min, 0);
    check_val("mid_sec", sec, 0);
    check_val("mid_sec_pulse", sec_pulse, 1);
    chime_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (hour_chime) chime_cycles++;
      step(1);
    end
    check_val("chime_cycles", chime_cycles, 4);

    // Manual minute wrap has no carry; a held level counts once
    set_mode = 1'b1;
    step(1);
    for (int i = 0; i < 59; i++) pulse_min();
    check_val("min59", min, 59);
    pulse_min();
    check_val("min_wrap", min, 0);
    check_val("min_wrap_hour", hour, 0);
    check_val("set_sec_pulse", sec_pulse, 0);
    inc_min = 1'b1; step(10);
    inc_min = 1'b0; step(1);
    check_val("held_inc_min", min, 1);
    set_mode = 1'b0;
    step(1);
    pulse_min();
    check_val("inc_ignored_run", min, 1);

    // Slots 1 and 2 at 00:01; lowest index rings, then auto-dismiss
    write_slot(1, 0, 1, 1'b1);
    write_slot(2, 0, 1, 1'b1);
    check_val("alm_en_12", alm_en, 6);
    set_mode = 1'b1;
    step(1);
    for (int i = 0; i < 59; i++) pulse_min();
    check_val("back_to_0000", min, 0);
    set_mode = 1'b0;
    step(236);
    check_val("at_0059_sec", sec, 59);
    check_val("at_0059_ringing", ringing, 0);
    step(4);
    check_val("ring_min", min, 1);
    check_val("ring_start", ringing, 1);
    check_val("ring_id_low", ring_id, 1);
    step(8);
    check_val("ring_still", ringing, 1);
    step(4);
    check_val("ring_timeout", ringing, 0);
    check_val("ring_timeout_snz", snoozed, 0);

    // Slot 3 at 00:02: snooze, re-ring after 60 s, dismiss
    write_slot(3, 0, 2, 1'b1);
    step(227);
    check_val("ring3_start", ringing, 1);
    check_val("ring3_id", ring_id, 3);
    snooze = 1'b1; step(1);
    snooze = 1'b0;
    check_val("snz_ringing", ringing, 0);
    check_val("snz_snoozed", snoozed, 1);
    step(238);
    check_val("snz_held", snoozed, 1);
    step(1);
    check_val("snz_rering", ringing, 1);
    check_val("snz_rering_id", ring_id, 3);
    dismiss = 1'b1; step(1);
    dismiss = 1'b0;
    check_val("dismiss_ringing", ringing, 0);
    check_val("dismiss_snoozed", snoozed, 0);
    snooze = 1'b1; step(1);
    snooze = 1'b0;
    check_val("idle_snooze_ign", snoozed, 0);
    check_val("idle_ring_id_hold", ring_id, 3);

    // Slot 0 at 00:04: simultaneous snooze+dismiss -> dismiss wins
    write_slot(0, 0, 4, 1'b1);
    step(237);
    check_val("ring0_start", ringing, 1);
    check_val("ring0_id", ring_id, 0);
    snooze = 1'b1; dismiss = 1'b1; step(1);
    check_val("both_ringing", ringing, 0);
    check_val("both_snoozed", snoozed, 0);
    snooze = 1'b0; dismiss = 1'b0; step(1);
    check_val("both_snoozed_after", snoozed, 0);

    // Slot 0 at 00:05: rewrite during RING leaves it ringing
    write_slot(0, 0, 5, 1'b1);
    step(237);
    check_val("ring5_start", ringing, 1);
    write_slot(0, 0, 9, 1'b0);
    check_val("wr_during_ring", ringing, 1);
    check_val("wr_during_ring_en", alm_en, 14);

    // Asynchronous reset mid-RING, between clock edges
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_ringing", ringing, 0);
    check_val("arst_min", min, 0);
    check_val("arst_alm_en", alm_en, 0);
    check_val("arst_ring_id", ring_id, 0);
    step(1);
    rst = 1'b1;
    step(1);
    check_val("post_rst_hour", hour, 0);
    check_val("post_rst_min", min, 0);
    check_val("post_rst_sec", sec, 0);
    check_val("post_rst_alm_en", alm_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
